// File: rtl/wb_line_master.sv
// rtl/wb_line_master.sv - Wishbone B3 wrapping-burst master moving one cache line per command
// Critical word first; read beats stream out, write beats stream in.
module wb_line_master #(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int beats   = 4,
  parameter int timeout = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [aw-1:0] cmd_adr_i,
  input  logic          wr_valid_i,
  input  logic [dw-1:0] wr_dat_i,
  output logic          wr_ready_o,
  output logic          rd_valid_o,
  output logic [dw-1:0] rd_dat_o,
  output logic [3:0]    rd_beat_o,
  output logic          done_o,
  output logic          err_o,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i
);
  localparam int lg = $clog2(beats);
  localparam int TW = $clog2(timeout + 2);
  localparam logic [TW-1:0] TO_LAST  = TW'(timeout > 0 ? timeout - 1 : 0);
  localparam logic [lg-1:0] CNT_LAST = lg'(beats - 1);
  localparam logic [1:0]    BTE      = (beats == 16) ? 2'b11 : (beats == 8) ? 2'b10 : 2'b01;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [aw-lg-3:0] base_q, base_d;
  logic [lg-1:0]    word_q, word_d;
  logic [lg-1:0]    cnt_q, cnt_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic [TW-1:0]    to_q, to_d;
  logic [aw-1:0]    adr_q, adr_d;

  logic          in_burst, stb, fault, ack_ok, last, to_hit;
  logic [lg-1:0] beat_idx, next_idx;

  assign in_burst = (state_q == S_BURST);
  // A write beat is only offered to the bus while the producer has data.
  assign stb      = in_burst & (we_q ? wr_valid_i : 1'b1);
  assign fault    = in_burst & (wb_err_i | wb_rty_i);
  assign ack_ok   = stb & wb_ack_i & ~wb_err_i & ~wb_rty_i;
  assign last     = (cnt_q == CNT_LAST);
  assign to_hit   = (timeout != 0) && stb && !wb_ack_i && !fault && (to_q == TO_LAST);
  assign beat_idx = word_q + cnt_q;
  assign next_idx = beat_idx + lg'(1);

  assign cmd_ready_o = (state_q == S_IDLE);
  assign wb_cyc_o    = in_burst;
  assign wb_stb_o    = stb;
  assign wb_we_o     = in_burst & we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = wr_dat_i;
  assign wb_sel_o    = 4'hf;
  assign wb_cti_o    = in_burst ? (last ? 3'b111 : 3'b010) : 3'b000;
  assign wb_bte_o    = BTE;
  assign rd_valid_o  = ack_ok & ~we_q;
  assign rd_dat_o    = wb_dat_i;
  assign rd_beat_o   = 4'(beat_idx);
  assign wr_ready_o  = ack_ok & we_q;
  assign done_o      = (state_q == S_DONE);
  assign err_o       = (state_q == S_DONE) & err_q;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = err_q;
    to_d    = to_q;
    adr_d   = adr_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          state_d = S_BURST;
          base_d  = cmd_adr_i[aw-1:lg+2];
          word_d  = cmd_adr_i[lg+1:2];
          we_d    = cmd_we_i;
          cnt_d   = '0;
          to_d    = '0;
          err_d   = 1'b0;
          adr_d   = cmd_adr_i & ~aw'(3);
        end
      end
      S_BURST: begin
        if (fault || to_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else if (ack_ok) begin
          to_d = '0;
          if (last) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + lg'(1);
            adr_d = {base_q, next_idx, 2'b00};
          end
        end else if (stb) begin
          to_d = to_q + TW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= '0;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      to_q    <= to_d;
      adr_q   <= adr_d;
    end
  end
endmodule

// File: doc/wb_line_master.md
Name: wb_line_master

Overview:
- Wishbone B3 burst master that moves one cache line per command.
- Sits directly upstream of the on-chip Wishbone RAM slave and drives its wb_* slave port.
- Converts a single line request (read refill or write-back, critical word first) into one wrapping B3 incrementing burst (cti 010 … 111, bte matched to line size).
- Streams read beats out and write beats in, with error and timeout reporting.

Parameters:
- dw, 32, data width (only 32 supported; sel is 4 bits).
- aw, 32, address width.
- beats, 4, words per line; legal values 4, 8, 16.
- timeout, 255, max cycles stb may stay high without ack/err before abort; 0 disables the timeout.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_ni  in  1  reset: one clock; reset is synchronous and active-low.
- cmd_valid_i  in  1  line request valid.
- cmd_ready_o  out  1  master idle; request accepted when valid & ready.
- cmd_we_i  in  1  1 = write-back, 0 = refill.
- cmd_adr_i  in  aw  byte address of the critical word; bits [1:0] ignored.
- wr_valid_i  in  1  write beat available.
- wr_dat_i  in  dw  write beat data.
- wr_ready_o  out  1  write beat consumed this cycle.
- rd_valid_o  out  1  read beat valid; no backpressure.
- rd_dat_o  out  dw  read beat data.
- rd_beat_o  out  4  word index of the beat within the line.
- done_o  out  1  one-cycle pulse at end of command.
- err_o  out  1  qualifies done_o; command ended on err, rty or timeout.
- wb_adr_o  out  aw  bus address.
- wb_dat_o  out  dw  bus write data.
- wb_sel_o  out  4  byte selects; constant 4'hf.
- wb_we_o  out  1  bus write enable.
- wb_cyc_o, wb_stb_o  out  1 each  bus cycle and strobe.
- wb_cti_o  out  3  cycle type.
- wb_bte_o  out  2  burst type: 01 for beats=4, 10 for 8, 11 for 16.
- wb_dat_i  in  dw  bus read data.
- wb_ack_i, wb_err_i, wb_rty_i  in  1 each  slave responses.

Behaviour:
- Reset (wb_rst_ni low at an edge):
  - state=IDLE; cyc, stb, we, done_o, err_o = 0; cti=000; adr=0; beat counter and timeout counter cleared.
  - Reset asserted mid-burst drops cyc/stb at that edge and produces no done pulse.
- States:
  - IDLE: cmd_ready_o=1.
  - BURST: cyc high.
  - DONE: exactly one cycle; done_o=1, cyc=0.
  - Transitions: IDLE->BURST on accept; BURST->DONE on last ack, err, rty or timeout; DONE->IDLE always.
- Latency:
  - Accept at edge T registers base = cmd_adr_i, word = cmd_adr_i[lg+1:2] with lg=log2(beats), and we.
  - cyc and first address are driven in the cycle after T.
  - Minimum command turnaround: 1 accept cycle + beats ack cycles + 1 DONE cycle. cyc is low for at least 2 cycles between bursts.
- Address generation:
  - wb_adr_o = {base[aw-1:lg+2], (word+cnt) mod beats, 2'b00}, with cnt = 0..beats-1.
  - wb_adr_o is registered and advances only at the edge where wb_ack_i=1.
  - Wrap is by lg-bit truncation; upper address bits never change within a burst.
- Cycle type: wb_cti_o=010 while cnt<beats-1 and 111 for the final beat; stable whenever stb=1.
- Read command:
  - stb high throughout BURST.
  - On each ack: rd_valid_o=1, rd_dat_o=wb_dat_i, rd_beat_o=(word+cnt) mod beats. These outputs are combinational from the ack cycle.
- Write command:
  - wb_stb_o = wr_valid_i while in BURST; cyc, adr and cti are held while stb is low.
  - wb_dat_o = wr_dat_i.
  - wr_ready_o = wb_ack_i & we & state==BURST.
  - The producer supplies beats in wrap order.
- Termination:
  - After the last ack, cyc, stb and we fall at the next edge.
  - wb_err_i or wb_rty_i in BURST ends the burst at the next edge with done_o=1, err_o=1. Beats already delivered stand; no retry.
  - A simultaneous ack+err is treated as err; that beat's rd_valid_o and wr_ready_o are suppressed.
- Timeout:
  - Counter increments each cycle with stb=1 and no ack/err, and clears on ack.
  - Reaching `timeout` aborts as an error.
  - Cycles with stb low (write stall) do not count.
- cmd_valid_i outside IDLE is ignored; cmd inputs are sampled only at accept.

Test Plan:
- Refill, beats=4, cmd_adr_i=0x0000_0108, slave acks every cycle -> adr sequence 0x108, 0x10C, 0x100, 0x104; cti 010, 010, 010, 111; bte=01; rd_beat_o 2, 3, 0, 1; done_o one cycle after the 4th ack, err_o=0.
- Write-back, beats=8, adr 0x200, wr_valid_i low for 3 cycles before beat 5 -> stb low for those cycles with adr 0x214 and cti 010 held; 8 wr_ready_o pulses; RAM read-back matches the 8 words.
- Slave asserts wb_err_i on beat 2 of a refill -> only 2 rd_valid_o pulses; cyc low at the next edge; done_o=1 with err_o=1.
- timeout=5, slave never acks -> stb high for exactly 5 cycles, then abort; done_o=1, err_o=1; cmd_ready_o=1 the following cycle.
- wb_rst_ni low during beat 3 of a 16-beat burst -> cyc, stb and cti=000 at that edge; no done_o; next command runs normally.
- Back-to-back commands with cmd_valid_i held high -> second cyc rises no earlier than 2 cycles after the first burst's last ack; the RAM slave acks both bursts without err.
